// File: rtl/clock_pkg.sv
// Shared types and constants for the time-setting controller.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_S  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    localparam int HOUR_MAX   = 23;
    localparam int MINSEC_MAX = 59;

    localparam logic [1:0] FIELD_NONE    = 2'd0;
    localparam logic [1:0] FIELD_HOURS   = 2'd1;
    localparam logic [1:0] FIELD_MINUTES = 2'd2;
    localparam logic [1:0] FIELD_SECONDS = 2'd3;

    function automatic logic [1:0] field_of(input state_e s);
        case (s)
            ST_SET_H: return FIELD_HOURS;
            ST_SET_M: return FIELD_MINUTES;
            ST_SET_S: return FIELD_SECONDS;
            default:  return FIELD_NONE;
        endcase
    endfunction

    function automatic logic is_edit(input state_e s);
        return (s == ST_SET_H) || (s == ST_SET_M) || (s == ST_SET_S);
    endfunction

endpackage

// File: rtl/clock_set_controller_wrap_updown.sv
// Registered up/down counter wrapping over 0..MAX, with a parallel load.
module wrap_updown #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] value_q, value_d;

    // Load has priority; inc and dec together cancel out.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (en_i && inc_i && !dec_i) begin
            value_d = (value_q == MAX_V) ? '0 : value_q + WIDTH'(1);
        end else if (en_i && dec_i && !inc_i) begin
            value_d = (value_q == '0) ? MAX_V : value_q - WIDTH'(1);
        end
    end

    // Value register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/clock_set_controller.sv
// Front-panel time-setting sequencer: edits shadow HH:MM:SS and strobes a load.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_RUN    | normal timekeeping, counter free-running
// ST_SET_H  | editing hours, counter frozen
// ST_SET_M  | editing minutes, counter frozen
// ST_SET_S  | editing seconds, counter frozen
// ST_COMMIT | one-cycle load strobe of the shadow values
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz_i,
    input  logic       tick_2hz_i,
    input  logic       mode_btn_i,
    input  logic       inc_btn_i,
    input  logic       dec_btn_i,
    input  logic [4:0] cur_hours_i,
    input  logic [5:0] cur_minutes_i,
    input  logic [5:0] cur_seconds_i,
    output logic       run_en_o,
    output logic       load_valid_o,
    output logic [4:0] load_hours_o,
    output logic [5:0] load_minutes_o,
    output logic [5:0] load_seconds_o,
    output logic [1:0] edit_field_o,
    output logic       blink_o
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_SEC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic [1:0]       field_q, field_d;
    logic             any_btn;
    logic             timeout;
    logic             capture;

    assign any_btn = mode_btn_i | inc_btn_i | dec_btn_i;
    assign timeout = tick_1hz_i && !any_btn && (cnt_q == CNT_TC);
    assign capture = (state_q == ST_RUN) && mode_btn_i;

    // Next state, inactivity counter, blink phase and field decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (mode_btn_i) state_d = ST_SET_H;
            ST_SET_H:  if (mode_btn_i) state_d = ST_SET_M;
                       else if (timeout) state_d = ST_RUN;
            ST_SET_M:  if (mode_btn_i) state_d = ST_SET_S;
                       else if (timeout) state_d = ST_RUN;
            ST_SET_S:  if (mode_btn_i) state_d = ST_COMMIT;
                       else if (timeout) state_d = ST_RUN;
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        cnt_d = cnt_q;
        if (!is_edit(state_q) || (state_d != state_q) || any_btn) cnt_d = '0;
        else if (tick_1hz_i)                                       cnt_d = cnt_q + CNT_W'(1);

        blink_d = blink_q;
        if (!is_edit(state_q) || !is_edit(state_d) || any_btn) blink_d = 1'b0;
        else if (tick_2hz_i)                                    blink_d = ~blink_q;

        field_d = field_of(state_d);
    end

    // State and auxiliary registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            blink_q <= 1'b0;
            field_q <= FIELD_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            field_q <= field_d;
        end
    end

    // Shadow fields; mode in an edit state swallows any inc/dec in that cycle.
    wrap_updown #(.WIDTH(5), .MAX(HOUR_MAX)) u_hours (
        .clk        (clk),
        .reset      (reset),
        .load_i     (capture),
        .load_val_i (cur_hours_i),
        .inc_i      (inc_btn_i),
        .dec_i      (dec_btn_i),
        .en_i       ((state_q == ST_SET_H) && !mode_btn_i),
        .value_o    (load_hours_o)
    );

    wrap_updown #(.WIDTH(6), .MAX(MINSEC_MAX)) u_minutes (
        .clk        (clk),
        .reset      (reset),
        .load_i     (capture),
        .load_val_i (cur_minutes_i),
        .inc_i      (inc_btn_i),
        .dec_i      (dec_btn_i),
        .en_i       ((state_q == ST_SET_M) && !mode_btn_i),
        .value_o    (load_minutes_o)
    );

    wrap_updown #(.WIDTH(6), .MAX(MINSEC_MAX)) u_seconds (
        .clk        (clk),
        .reset      (reset),
        .load_i     (capture),
        .load_val_i (cur_seconds_i),
        .inc_i      (inc_btn_i),
        .dec_i      (dec_btn_i),
        .en_i       ((state_q == ST_SET_S) && !mode_btn_i),
        .value_o    (load_seconds_o)
    );

    assign run_en_o     = (state_q == ST_RUN);
    assign load_valid_o = (state_q == ST_COMMIT);
    assign edit_field_o = field_q;
    assign blink_o      = blink_q;

endmodule
